pipe_rc_adder: RTL and testbench

- Parametrised, pipelined successor to the combinational ripple-carry adder.
- Splits a WIDTH-bit add/subtract into STAGES carry-propagating slices, one register stage per slice. Operands are skewed so throughput is one operation per cycle.
- Valid/ready handshake on input and output. Used as the datapath adder wherever the combinational ripple path fails timing.

---
 rtl/pipe_rc_adder.sv | 141 ++++++++++++++
 tb/tb_pipe_rc_adder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_rc_adder.sv
// Pipelined ripple-carry add/subtract: WIDTH bits split into STAGES slices, one register per slice.
// Optional signed-overflow output enabled by defining PIPE_RC_ADDER_OVF_EN.
module pipe_rc_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
`ifdef PIPE_RC_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);

  localparam int CHUNK = WIDTH / STAGES;

  if ((STAGES < 1) || ((WIDTH % STAGES) != 0)) begin : g_bad_cfg
    $error("pipe_rc_adder: WIDTH must be a non-zero multiple of STAGES");
  end

  logic              adv_s;
  logic [STAGES-1:0] vld_q, vld_d;
  logic [STAGES-1:0] cry_q, cry_d;
  logic [WIDTH-1:0]  opa_q [STAGES];
  logic [WIDTH-1:0]  opa_d [STAGES];
  logic [WIDTH-1:0]  opb_q [STAGES];
  logic [WIDTH-1:0]  opb_d [STAGES];
  logic [WIDTH-1:0]  res_q [STAGES];
  logic [WIDTH-1:0]  res_d [STAGES];

  logic [STAGES-1:0] src_vld_s;
  logic [STAGES-1:0] src_cry_s;
  logic [WIDTH-1:0]  src_a_s   [STAGES];
  logic [WIDTH-1:0]  src_b_s   [STAGES];
  logic [WIDTH-1:0]  src_res_s [STAGES];
  logic [CHUNK:0]    slice_s   [STAGES];

  // Stall is global: everything moves only when the output slot is free or being taken.
  assign adv_s    = !vld_q[STAGES-1] || out_ready;
  assign in_ready = adv_s;

  // Per-stage source operands; bubbles enter as all-zero data so no X reaches the output.
  always_comb begin
    src_vld_s[0] = in_valid;
    src_a_s[0]   = in_valid ? a : {WIDTH{1'b0}};
    src_b_s[0]   = in_valid ? (b ^ {WIDTH{sub}}) : {WIDTH{1'b0}};
    src_cry_s[0] = in_valid & (sub | cin);
    src_res_s[0] = {WIDTH{1'b0}};
    for (int k = 1; k < STAGES; k++) begin
      src_vld_s[k] = vld_q[k-1];
      src_a_s[k]   = opa_q[k-1];
      src_b_s[k]   = opb_q[k-1];
      src_cry_s[k] = cry_q[k-1];
      src_res_s[k] = res_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      slice_s[k] = {1'b0, src_a_s[k][k*CHUNK +: CHUNK]}
                 + {1'b0, src_b_s[k][k*CHUNK +: CHUNK]}
                 + {{CHUNK{1'b0}}, src_cry_s[k]};
    end
  end

  // Next state: each stage adds its slice and inserts it into the partial result.
  always_comb begin
    vld_d = vld_q;
    cry_d = cry_q;
    opa_d = opa_q;
    opb_d = opb_q;
    res_d = res_q;
    if (adv_s) begin
      vld_d = src_vld_s;
      for (int k = 0; k < STAGES; k++) begin
        cry_d[k] = slice_s[k][CHUNK];
        opa_d[k] = src_a_s[k];
        opb_d[k] = src_b_s[k];
        res_d[k] = src_res_s[k];
        res_d[k][k*CHUNK +: CHUNK] = slice_s[k][CHUNK-1:0];
      end
    end else begin
      vld_d = vld_q;
    end
  end

  // Pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= {STAGES{1'b0}};
      cry_q <= {STAGES{1'b0}};
      for (int k = 0; k < STAGES; k++) begin
        opa_q[k] <= {WIDTH{1'b0}};
        opb_q[k] <= {WIDTH{1'b0}};
        res_q[k] <= {WIDTH{1'b0}};
      end
    end else begin
      vld_q <= vld_d;
      cry_q <= cry_d;
      opa_q <= opa_d;
      opb_q <= opb_d;
      res_q <= res_d;
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign sum       = res_q[STAGES-1];
  assign cout      = cry_q[STAGES-1];

`ifdef PIPE_RC_ADDER_OVF_EN
  logic ovf_q, ovf_d;

  // Carry into the MSB is recovered as sum_msb ^ a_msb ^ b_msb.
  always_comb begin
    if (adv_s) begin
      ovf_d = slice_s[STAGES-1][CHUNK] ^ slice_s[STAGES-1][CHUNK-1]
            ^ src_a_s[STAGES-1][WIDTH-1] ^ src_b_s[STAGES-1][WIDTH-1];
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Overflow flag register travels with the last stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_pipe_rc_adder.sv
// Directed self-checking bench for pipe_rc_adder (WIDTH=16, STAGES=4).
module tb_pipe_rc_adder;
  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
`ifdef PIPE_RC_ADDER_OVF_EN
  logic        ovf;
`endif

  int errors = 0;
  int checks = 0;

  // i*0x1111 + 0x0F0F for i = 0..7, computed by hand
  logic [15:0] exp_stream [8] = '{16'h0F0F, 16'h2020, 16'h3131, 16'h4242,
                                  16'h5353, 16'h6464, 16'h7575, 16'h8686};

  pipe_rc_adder #(.WIDTH(16), .STAGES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
`ifdef PIPE_RC_ADDER_OVF_EN
    .ovf(ovf),
`endif
    .cout(cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    in_valid = 1'b0;
    a = 16'h0000;
    b = 16'h0000;
    cin = 1'b0;
    sub = 1'b0;
  endtask

  // Issue one beat and wait for its result; lat counts rising edges from issue to out_valid.
  task automatic single_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc,
                           input logic ts, output logic [15:0] rs, output logic rc,
                           output logic ro, output int lat);
    a = ta; b = tb_v; cin = tc; sub = ts; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    idle_inputs();
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rs = sum;
    rc = cout;
`ifdef PIPE_RC_ADDER_OVF_EN
    ro = ovf;
`else
    ro = 1'b0;
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; out_ready = 1'b1; idle_inputs();
    #12;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (sum !== 16'h0000) begin errors++; $display("FAIL reset_sum got=%h want=0000", sum); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout got=%b want=0", cout); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
`ifdef PIPE_RC_ADDER_OVF_EN
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b want=0", ovf); end
`endif
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_out_valid got=%b want=0", out_valid); end
  endtask

  task automatic test_carry_chain();
    logic [15:0] rs; logic rc, ro; int lat;
    single_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, rs, rc, ro, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL carry_latency got=%0d want=4", lat); end
    checks++; if (rs !== 16'h0000) begin errors++; $display("FAIL carry_sum got=%h want=0000", rs); end
    checks++; if (rc !== 1'b1) begin errors++; $display("FAIL carry_cout got=%b want=1", rc); end
`ifdef PIPE_RC_ADDER_OVF_EN
    checks++; if (ro !== 1'b0) begin errors++; $display("FAIL carry_ovf got=%b want=0", ro); end
`endif
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL carry_drained got=%b want=0", out_valid); end
    single_op(16'h1234, 16'h0FF0, 1'b1, 1'b0, rs, rc, ro, lat);
    checks++; if (rs !== 16'h2225) begin errors++; $display("FAIL cin_sum got=%h want=2225", rs); end
    checks++; if (rc !== 1'b0) begin errors++; $display("FAIL cin_cout got=%b want=0", rc); end
  endtask

  task automatic test_subtract();
    logic [15:0] rs; logic rc, ro; int lat;
    single_op(16'h0005, 16'h0007, 1'b1, 1'b1, rs, rc, ro, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL sub_latency got=%0d want=4", lat); end
    checks++; if (rs !== 16'hFFFE) begin errors++; $display("FAIL sub_borrow_sum got=%h want=fffe", rs); end
    checks++; if (rc !== 1'b0) begin errors++; $display("FAIL sub_borrow_cout got=%b want=0", rc); end
    single_op(16'h0007, 16'h0005, 1'b0, 1'b1, rs, rc, ro, lat);
    checks++; if (rs !== 16'h0002) begin errors++; $display("FAIL sub_sum got=%h want=0002", rs); end
    checks++; if (rc !== 1'b1) begin errors++; $display("FAIL sub_cout got=%b want=1", rc); end
  endtask

  task automatic test_overflow();
    logic [15:0] rs; logic rc, ro; int lat;
    single_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, rs, rc, ro, lat);
    checks++; if (rs !== 16'h8000) begin errors++; $display("FAIL ovf_add_sum got=%h want=8000", rs); end
    checks++; if (rc !== 1'b0) begin errors++; $display("FAIL ovf_add_cout got=%b want=0", rc); end
`ifdef PIPE_RC_ADDER_OVF_EN
    checks++; if (ro !== 1'b1) begin errors++; $display("FAIL ovf_add_flag got=%b want=1", ro); end
`endif
    single_op(16'h8000, 16'h0001, 1'b0, 1'b1, rs, rc, ro, lat);
    checks++; if (rs !== 16'h7FFF) begin errors++; $display("FAIL ovf_sub_sum got=%h want=7fff", rs); end
    checks++; if (rc !== 1'b1) begin errors++; $display("FAIL ovf_sub_cout got=%b want=1", rc); end
`ifdef PIPE_RC_ADDER_OVF_EN
    checks++; if (ro !== 1'b1) begin errors++; $display("FAIL ovf_sub_flag got=%b want=1", ro); end
`endif
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      if (k <= 8) begin
        in_valid = 1'b1; a = 16'(k - 1) * 16'h1111; b = 16'h0F0F; cin = 1'b0; sub = 1'b0;
      end else begin
        idle_inputs();
      end
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready k=%0d got=%b want=1", k, in_ready); end
      @(posedge clk); #1;
      if (k >= 4 && k <= 11) begin
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_out_valid k=%0d got=%b want=1", k, out_valid); end
        checks++; if (sum !== exp_stream[k-4]) begin errors++; $display("FAIL b2b_sum k=%0d got=%h want=%h", k, sum, exp_stream[k-4]); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL b2b_cout k=%0d got=%b want=0", k, cout); end
      end else begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle k=%0d got=%b want=0", k, out_valid); end
      end
    end
  endtask

  task automatic test_backpressure();
    int nin = 0;
    int nout = 0;
    logic stall;
    for (int k = 1; k <= 30 && nout < 8; k++) begin
      stall = (k >= 5 && k <= 7);
      out_ready = !stall;
      if (nin < 8) begin
        in_valid = 1'b1; a = 16'(nin) * 16'h1111; b = 16'h0F0F; cin = 1'b0; sub = 1'b0;
      end else begin
        idle_inputs();
      end
      #1;
      checks++; if (in_ready !== !stall) begin errors++; $display("FAIL bp_in_ready k=%0d got=%b want=%b", k, in_ready, !stall); end
      if (k >= 5 && k <= 15) begin
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid k=%0d got=%b want=1", k, out_valid); end
        checks++; if (sum !== exp_stream[nout]) begin errors++; $display("FAIL bp_sum k=%0d got=%h want=%h", k, sum, exp_stream[nout]); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL bp_cout k=%0d got=%b want=0", k, cout); end
        if (!stall) nout++;
      end else begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_idle k=%0d got=%b want=0", k, out_valid); end
      end
      if (nin < 8 && !stall) nin++;
      @(posedge clk); #1;
    end
    idle_inputs(); out_ready = 1'b1;
    checks++; if (nout !== 8) begin errors++; $display("FAIL bp_drained got=%0d want=8", nout); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got=%b want=0", out_valid); end
  endtask

  task automatic test_reset_midflight();
    logic [15:0] rs; logic rc, ro; int lat;
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; a = 16'(k + 1) * 16'h1111; b = 16'h0F0F; cin = 1'b0; sub = 1'b0;
      @(posedge clk); #1;
    end
    idle_inputs();
    checks++; if (sum !== 16'h2020) begin errors++; $display("FAIL rst_pre_sum got=%h want=2020", sum); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_async_valid got=%b want=0", out_valid); end
    checks++; if (sum !== 16'h0000) begin errors++; $display("FAIL rst_async_sum got=%h want=0000", sum); end
    @(posedge clk); @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_stale k=%0d got=%b want=0", k, out_valid); end
    end
    single_op(16'h0100, 16'h0023, 1'b1, 1'b0, rs, rc, ro, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL rst_new_latency got=%0d want=4", lat); end
    checks++; if (rs !== 16'h0124) begin errors++; $display("FAIL rst_new_sum got=%h want=0124", rs); end
  endtask

  initial begin
    test_reset();
    test_carry_chain();
    test_subtract();
    test_overflow();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end
endmodule
